// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding,
// oversampling constants, sample positions and frame size default.
package uart_pkg;

    // Receiver FSM state encoding (2 bits)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BIT   = 2'd2
    } rx_state_t;

    // Ticks per bit period
    localparam int OVERSAMPLE = 16;

    // Sample positions within a bit period (in ticks)
    localparam int SMP_EARLY = 7;
    localparam int SMP_MID   = 8;
    localparam int SMP_LATE  = 9;

    // Default frame length after the start bit: 8 data + parity + stop
    localparam int FRAME_BITS_DEF = 10;

    // 2-of-3 majority
    function automatic logic maj3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Free-running prescaler producing the oversample tick.
// Ports: clk, reset (sync, active-low), tick (high when count==CLK_DIV-1).
module rx_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // With CLK_DIV=1 LAST is 0, so the counter sits at 0 and tick is constant high
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/rx_sampler.sv
// Oversampling serial receiver front end: synchronizes rx_in, detects and
// validates the start bit, then votes each frame bit near mid-bit.
// Ports: clk, reset (sync, active-low), rx_in (async, idle high),
//   zero_detected / one_detected / bit_valid (1-cycle pulses),
//   bit_value (held), bit_index[3:0], busy.
// Build option: RX_MAJORITY_VOTE_EN selects a 3-sample majority vote at
//   ticks 7/8/9; without it only the tick-8 sample decides.
module rx_sampler
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic       zero_detected,
    output logic       one_detected,
    output logic       bit_valid,
    output logic       bit_value,
    output logic [3:0] bit_index,
    output logic       busy
);

    localparam logic [3:0] LAST_IDX  = 4'(FRAME_BITS - 1);
    localparam logic [3:0] POS_EARLY = 4'(SMP_EARLY);
    localparam logic [3:0] POS_MID   = 4'(SMP_MID);
    localparam logic [3:0] POS_LATE  = 4'(SMP_LATE);
    localparam logic [3:0] POS_END   = 4'(OVERSAMPLE - 1);

    logic      w_tick;
    logic      r_sync1;
    logic      r_sync2;
    logic      w_rx;

    rx_state_t r_state;
    logic [3:0] r_scnt;
    logic [3:0] r_bidx;
    logic      r_zero;
    logic      r_one;
    logic      r_valid;
    logic      r_value;
    logic      r_busy;

    logic      w_at_mid;
    logic      w_at_late;
    logic      w_at_end;
    logic      w_last_bit;
    logic      w_vote;
    logic      r_s8;

    rx_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Two-flop synchronizer, idle-high
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx = r_sync2;

    assign w_at_mid   = w_tick && (r_scnt == POS_MID);
    assign w_at_late  = w_tick && (r_scnt == POS_LATE);
    assign w_at_end   = w_tick && (r_scnt == POS_END);
    assign w_last_bit = (r_bidx == LAST_IDX);

    // The tick-9 sample is taken straight from the synchronizer on the
    // deciding edge, so the registered outputs appear one clock after it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s8 <= 1'b1;
        end else if (w_at_mid) begin
            r_s8 <= w_rx;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic w_at_early;
    logic r_s7;

    assign w_at_early = w_tick && (r_scnt == POS_EARLY);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s7 <= 1'b1;
        end else if (w_at_early) begin
            r_s7 <= w_rx;
        end
    end

    assign w_vote = maj3(r_s7, r_s8, w_rx);
`else
    assign w_vote = r_s8;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_scnt  <= '0;
            r_bidx  <= '0;
            r_zero  <= 1'b0;
            r_one   <= 1'b0;
            r_valid <= 1'b0;
            r_value <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_zero  <= 1'b0;
            r_one   <= 1'b0;
            r_valid <= 1'b0;

            // Sample counter wraps 15->0 on its own
            if (w_tick) begin
                r_scnt <= r_scnt + 4'd1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    r_scnt <= '0;
                    if (w_tick && !w_rx) begin
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_at_late) begin
                        if (!w_vote) begin
                            r_zero <= 1'b1;
                            r_busy <= 1'b1;
                        end else begin
                            // False start: line was only glitched low
                            r_state <= ST_IDLE;
                            r_scnt  <= '0;
                        end
                    end else if (w_at_end) begin
                        r_state <= ST_BIT;
                        r_scnt  <= '0;
                        r_bidx  <= '0;
                    end
                end

                ST_BIT: begin
                    if (w_at_late) begin
                        r_valid <= 1'b1;
                        r_value <= w_vote;
                        r_zero  <= !w_vote;
                        r_one   <= w_vote;
                        // Leave mid-stop-bit so the next start edge is seen early
                        if (w_last_bit) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_scnt  <= '0;
                        end
                    end else if (w_at_end && !w_last_bit) begin
                        r_bidx <= r_bidx + 4'd1;
                        r_scnt <= '0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_scnt  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign zero_detected = r_zero;
    assign one_detected  = r_one;
    assign bit_valid     = r_valid;
    assign bit_value     = r_value;
    assign bit_index     = r_bidx;
    assign busy          = r_busy;

endmodule
